// File: rtl/arrow_lane_tracker.sv
// Game-state tracker for one arrow lane: spawns arrows, scrolls them each video
// frame, judges player presses against the target line, and keeps combo/score.
module arrow_lane_tracker #(
    parameter int SLOTS       = 4,
    parameter int Y_W         = 11,
    parameter int SPAWN_Y     = 480,
    parameter int TARGET_Y    = 165,
    parameter int SPEED       = 2,
    parameter int WIN_PERFECT = 8,
    parameter int WIN_GOOD    = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_tick,
    input  logic                       spawn_valid,
    output logic                       spawn_ready,
    input  logic                       hit_press,
    output logic [SLOTS-1:0]           slot_valid,
    output logic [SLOTS*Y_W-1:0]       slot_y,
    output logic                       judge_valid,
    output logic [1:0]                 judge_code,
    output logic                       miss_valid,
    output logic [$clog2(SLOTS+1)-1:0] miss_num,
    output logic [15:0]                combo,
    output logic [15:0]                score
);

    localparam int CNT_W = $clog2(SLOTS + 1);
    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic signed [Y_W:0] MISS_LIM_S = (Y_W + 1)'(TARGET_Y - WIN_GOOD);

    function automatic logic [Y_W-1:0] abs_dist(input logic [Y_W-1:0] y);
        logic [Y_W-1:0] t;
        t = Y_W'(TARGET_Y);
        abs_dist = (y >= t) ? (y - t) : (t - y);
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'b0, b};
        sat_add = s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [SLOTS-1:0] slot_valid_r;
    logic [Y_W-1:0]   slot_y_r [SLOTS];
    logic             judge_valid_r;
    logic [1:0]       judge_code_r;
    logic             miss_valid_r;
    logic [CNT_W-1:0] miss_num_r;
    logic [15:0]      combo_r;
    logic [15:0]      score_r;

    logic [Y_W-1:0]   dist_s [SLOTS];
    logic             best_found_s;
    logic [IDX_W-1:0] best_idx_s;
    logic [Y_W-1:0]   best_dist_s;
    logic             take_s;
    logic [IDX_W-1:0] free_idx_s;
    logic             spawn_fire_s;
    logic [1:0]       judge_code_s;
    logic             hit_clear_s;
    logic signed [Y_W:0] y_next_s;
    logic [SLOTS-1:0] nv_s;
    logic [Y_W-1:0]   ny_s [SLOTS];
    logic [CNT_W-1:0] miss_cnt_s;
    logic [15:0]      combo_next_s;
    logic [15:0]      score_next_s;

    assign spawn_ready  = ~rst & ~(&slot_valid_r);
    assign spawn_fire_s = spawn_valid & spawn_ready;

    // Nearest-arrow search (strict < keeps the lowest index on ties) and free-slot pick.
    always_comb begin
        best_found_s = 1'b0;
        best_idx_s   = '0;
        best_dist_s  = '1;
        take_s       = 1'b0;
        free_idx_s   = '0;
        for (int i = 0; i < SLOTS; i++) begin
            dist_s[i]    = abs_dist(slot_y_r[i]);
            take_s       = slot_valid_r[i] & (~best_found_s | (dist_s[i] < best_dist_s));
            best_idx_s   = take_s ? IDX_W'(i) : best_idx_s;
            best_dist_s  = take_s ? dist_s[i] : best_dist_s;
            best_found_s = best_found_s | take_s;
        end
        for (int i = SLOTS - 1; i >= 0; i--) begin
            free_idx_s = slot_valid_r[i] ? free_idx_s : IDX_W'(i);
        end
    end

    // Judgement of the current press; the code doubles as the score increment.
    always_comb begin
        if (!hit_press || !best_found_s) begin
            judge_code_s = 2'b00;
        end else if (best_dist_s <= Y_W'(WIN_PERFECT)) begin
            judge_code_s = 2'b10;
        end else if (best_dist_s <= Y_W'(WIN_GOOD)) begin
            judge_code_s = 2'b01;
        end else begin
            judge_code_s = 2'b00;
        end
        hit_clear_s = hit_press & (judge_code_s != 2'b00);
    end

    // Per-slot next state: a judged slot is cleared before scrolling, spawns land on free slots.
    always_comb begin
        miss_cnt_s = '0;
        y_next_s   = '0;
        for (int i = 0; i < SLOTS; i++) begin
            nv_s[i]  = slot_valid_r[i];
            ny_s[i]  = slot_y_r[i];
            y_next_s = $signed({1'b0, slot_y_r[i]}) - $signed((Y_W + 1)'(SPEED));
            if (hit_clear_s && (best_idx_s == IDX_W'(i))) begin
                nv_s[i] = 1'b0;
            end else if (frame_tick && slot_valid_r[i]) begin
                if (y_next_s < MISS_LIM_S) begin
                    nv_s[i]    = 1'b0;
                    miss_cnt_s = miss_cnt_s + CNT_W'(1);
                end else begin
                    ny_s[i] = y_next_s[Y_W-1:0];
                end
            end else begin
                nv_s[i] = slot_valid_r[i];
            end
            if (spawn_fire_s && (free_idx_s == IDX_W'(i))) begin
                nv_s[i] = 1'b1;
                ny_s[i] = Y_W'(SPAWN_Y);
            end else begin
                ny_s[i] = ny_s[i];
            end
        end
    end

    // Counters: any miss this cycle wins over a hit for the combo, but the hit still scores.
    always_comb begin
        score_next_s = sat_add(score_r, judge_code_s);
        if (miss_cnt_s != '0) begin
            combo_next_s = 16'h0000;
        end else if (hit_press) begin
            combo_next_s = hit_clear_s ? sat_add(combo_r, 2'd1) : 16'h0000;
        end else begin
            combo_next_s = combo_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid_r  <= '0;
            judge_valid_r <= 1'b0;
            judge_code_r  <= 2'b00;
            miss_valid_r  <= 1'b0;
            miss_num_r    <= '0;
            combo_r       <= 16'h0000;
            score_r       <= 16'h0000;
            for (int i = 0; i < SLOTS; i++) begin
                slot_y_r[i] <= '0;
            end
        end else begin
            slot_valid_r  <= nv_s;
            judge_valid_r <= hit_press;
            judge_code_r  <= judge_code_s;
            miss_valid_r  <= (miss_cnt_s != '0);
            miss_num_r    <= miss_cnt_s;
            combo_r       <= combo_next_s;
            score_r       <= score_next_s;
            for (int i = 0; i < SLOTS; i++) begin
                slot_y_r[i] <= ny_s[i];
            end
        end
    end

    // Flatten slot positions onto the output bus.
    always_comb begin
        slot_y = '0;
        for (int i = 0; i < SLOTS; i++) begin
            slot_y[i*Y_W +: Y_W] = slot_y_r[i];
        end
    end

    assign slot_valid  = slot_valid_r;
    assign judge_valid = judge_valid_r;
    assign judge_code  = judge_code_r;
    assign miss_valid  = miss_valid_r;
    assign miss_num    = miss_num_r;
    assign combo       = combo_r;
    assign score       = score_r;

endmodule

// File: tb/tb_arrow_lane_tracker.sv
// Directed bench for arrow_lane_tracker: a vector table for single-cycle behaviour
// plus hand-written sequences for scrolling, judging, misses and saturation.
module tb_arrow_lane_tracker;

    localparam int SLOTS = 4;
    localparam int Y_W   = 11;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 frame_tick;
    logic                 spawn_valid;
    logic                 spawn_ready;
    logic                 hit_press;
    logic [SLOTS-1:0]     slot_valid;
    logic [SLOTS*Y_W-1:0] slot_y;
    logic                 judge_valid;
    logic [1:0]           judge_code;
    logic                 miss_valid;
    logic [2:0]           miss_num;
    logic [15:0]          combo;
    logic [15:0]          score;

    int errs   = 0;
    int checks = 0;

    arrow_lane_tracker dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
        .hit_press(hit_press), .slot_valid(slot_valid), .slot_y(slot_y),
        .judge_valid(judge_valid), .judge_code(judge_code),
        .miss_valid(miss_valid), .miss_num(miss_num),
        .combo(combo), .score(score)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ft, sv, hp;
        logic [3:0] vld;
        logic       rdy, jv;
        logic [1:0] jc;
        logic [15:0] cmb, scr;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs at a falling edge; outputs are sampled at the next falling edge.
    task automatic step(input logic ft, input logic sv, input logic hp);
        frame_tick  = ft;
        spawn_valid = sv;
        hit_press   = hp;
        @(negedge clk);
        frame_tick  = 1'b0;
        spawn_valid = 1'b0;
        hit_press   = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic chk_y(input string name, input int idx, input int exp);
        chk(name, 32'(slot_y[idx*Y_W +: Y_W]), 32'(exp));
    endtask

    task automatic chk_judge(input string name, input logic [1:0] jc, input logic [3:0] vld,
                             input int cmb, input int scr);
        chk({name, "_jv"}, 32'(judge_valid), 32'd1);
        chk({name, "_jc"}, 32'(judge_code), 32'(jc));
        chk({name, "_vld"}, 32'(slot_valid), 32'(vld));
        chk({name, "_combo"}, 32'(combo), 32'(cmb));
        chk({name, "_score"}, 32'(score), 32'(scr));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; spawn_valid = 1'b0; hit_press = 1'b0;
        //          ft    sv    hp    vld      rdy   jv    jc     combo   score
        tbl[0] = '{1'b0, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0, 2'b00, 16'd0, 16'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b1, 2'b00, 16'd0, 16'd0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 4'b0011, 1'b1, 1'b1, 2'b00, 16'd0, 16'd0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 4'b0111, 1'b1, 1'b0, 2'b00, 16'd0, 16'd0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 2'b00, 16'd0, 16'd0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 2'b00, 16'd0, 16'd0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0, 2'b00, 16'd0, 16'd0};

        // Reset state (press held during reset must not pulse).
        @(negedge clk);
        hit_press = 1'b1;
        @(negedge clk);
        hit_press = 1'b0;
        chk("rst_ready", 32'(spawn_ready), 32'd0);
        chk("rst_valid", 32'(slot_valid), 32'd0);
        chk("rst_y", 32'(slot_y[31:0]), 32'd0);
        chk("rst_jv", 32'(judge_valid), 32'd0);
        chk("rst_jc", 32'(judge_code), 32'd0);
        chk("rst_mv", 32'(miss_valid), 32'd0);
        chk("rst_mn", 32'(miss_num), 32'd0);
        chk("rst_combo", 32'(combo), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        chk("post_rst_jv", 32'(judge_valid), 32'd0);
        chk("post_rst_ready", 32'(spawn_ready), 32'd1);

        // Table: spawn, press with no candidate in range, same-cycle spawn/press/tick, full stall.
        for (int v = 0; v < 7; v++) begin
            step(tbl[v].ft, tbl[v].sv, tbl[v].hp);
            chk($sformatf("tbl%0d_vld", v), 32'(slot_valid), 32'(tbl[v].vld));
            chk($sformatf("tbl%0d_rdy", v), 32'(spawn_ready), 32'(tbl[v].rdy));
            chk($sformatf("tbl%0d_jv", v), 32'(judge_valid), 32'(tbl[v].jv));
            if (tbl[v].jv) chk($sformatf("tbl%0d_jc", v), 32'(judge_code), 32'(tbl[v].jc));
            chk($sformatf("tbl%0d_combo", v), 32'(combo), 32'(tbl[v].cmb));
            chk($sformatf("tbl%0d_score", v), 32'(score), 32'(tbl[v].scr));
            if (v == 0) chk_y("tbl0_y0", 0, 480);
        end
        chk_y("tbl_y0", 0, 478);
        chk_y("tbl_y1", 1, 478);
        chk_y("tbl_y2", 2, 480);
        chk_y("tbl_y3", 3, 480);

        // Reset mid-game drops all arrows.
        do_reset();
        chk("rst2_valid", 32'(slot_valid), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("rst2_jv", 32'(judge_valid), 32'd0);

        // PERFECT at y=166.
        step(1'b0, 1'b1, 1'b0);
        ticks(157);
        chk_y("perf_y", 0, 166);
        step(1'b0, 1'b0, 1'b1);
        chk_judge("perf", 2'b10, 4'b0000, 1, 2);
        step(1'b0, 1'b0, 1'b0);
        chk("perf_jv_pulse", 32'(judge_valid), 32'd0);

        // GOOD at y=180.
        step(1'b0, 1'b1, 1'b0);
        ticks(150);
        chk_y("good_y", 0, 180);
        step(1'b0, 1'b0, 1'b1);
        chk_judge("good", 2'b01, 4'b0000, 2, 3);

        // NONE at y=280: slot kept, combo broken.
        step(1'b0, 1'b1, 1'b0);
        ticks(100);
        step(1'b0, 1'b0, 1'b1);
        chk_judge("none", 2'b00, 4'b0001, 0, 3);

        // Second arrow; hit the first, let the second scroll past the miss line.
        step(1'b0, 1'b1, 1'b0);
        ticks(57);
        chk_y("m_y0", 0, 166);
        chk_y("m_y1", 1, 366);
        step(1'b0, 1'b0, 1'b1);
        chk_judge("m_hit", 2'b10, 4'b0010, 1, 5);
        ticks(112);
        chk_y("m_y142", 1, 142);
        chk("m_pre_vld", 32'(slot_valid), 32'b0010);
        chk("m_pre_mv", 32'(miss_valid), 32'd0);
        ticks(1);
        chk("miss_vld", 32'(slot_valid), 32'd0);
        chk("miss_mv", 32'(miss_valid), 32'd1);
        chk("miss_mn", 32'(miss_num), 32'd1);
        chk("miss_combo", 32'(combo), 32'd0);
        chk("miss_score", 32'(score), 32'd5);
        step(1'b0, 1'b0, 1'b0);
        chk("miss_pulse", 32'(miss_valid), 32'd0);

        // Fill with spawn_valid held six cycles.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b1, 1'b0);
            chk($sformatf("fill%0d_vld", k), 32'(slot_valid), (k < 3) ? ((32'd1 << (k + 1)) - 32'd1) : 32'd15);
            chk($sformatf("fill%0d_rdy", k), 32'(spawn_ready), (k < 3) ? 32'd1 : 32'd0);
        end
        ticks(150);
        step(1'b0, 1'b0, 1'b1);
        chk_judge("tie4", 2'b01, 4'b1110, 1, 1);
        step(1'b0, 1'b1, 1'b0);
        ticks(7);
        chk_y("t_y0", 0, 466);
        chk_y("t_y3", 3, 166);
        step(1'b0, 1'b0, 1'b1);
        chk_judge("tie3", 2'b10, 4'b1101, 2, 3);
        step(1'b0, 1'b1, 1'b0);
        chk("refill1_vld", 32'(slot_valid), 32'd15);

        // Press + frame_tick + spawn together while full, slot 2 nearest.
        step(1'b1, 1'b1, 1'b1);
        chk_judge("combo_cyc", 2'b10, 4'b1011, 3, 5);
        chk_y("cc_y0", 0, 464);
        chk_y("cc_y1", 1, 478);
        chk_y("cc_y3", 3, 164);
        chk("cc_mv", 32'(miss_valid), 32'd0);
        step(1'b0, 1'b1, 1'b0);
        chk("cc_refill_vld", 32'(slot_valid), 32'd15);
        chk_y("cc_refill_y2", 2, 480);
        chk("cc_refill_rdy", 32'(spawn_ready), 32'd0);

        // Score saturation.
        force dut.score_r = 16'hFFFE;
        #1;
        release dut.score_r;
        step(1'b0, 1'b0, 1'b1);
        chk_judge("sat", 2'b10, 4'b0111, 4, 16'hFFFF);
        step(1'b0, 1'b0, 1'b1);
        chk_judge("sat_none", 2'b00, 4'b0111, 0, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
